// File: rtl/axi_read_arbiter_pkg.sv
// Shared types and constants for the two-master / two-slave AXI read arbiter.
package axi_arb_pkg;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int MID_W   = 4;
   localparam int SID_W   = 8;
   localparam int LEN_W   = 4;
   localparam int SIZE_W  = 3;
   localparam int BURST_W = 2;
   localparam int RESP_W  = 2;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_ADDR = 2'd1;
   localparam state_t ST_DATA = 2'd2;
   localparam state_t ST_DEFR = 2'd3;

   typedef logic mst_idx_t;
   localparam mst_idx_t MST_M0 = 1'b0;
   localparam mst_idx_t MST_M1 = 1'b1;

   typedef logic slv_sel_t;

   localparam logic [RESP_W-1:0] RRESP_DECERR = 2'b11;

   typedef struct packed {
      logic [MID_W-1:0]   id;
      logic [ADDR_W-1:0]  addr;
      logic [LEN_W-1:0]   len;
      logic [SIZE_W-1:0]  size;
      logic [BURST_W-1:0] burst;
   } ar_pld_t;

endpackage

// File: rtl/axi_read_arbiter_if.sv
// AXI read-channel bundle (AR + R); ID_W differs between master and slave sides.
interface axi_rd_if #(parameter int ID_W = 4);
   import axi_arb_pkg::*;

   logic [ID_W-1:0]    ARID;
   logic [ADDR_W-1:0]  ARADDR;
   logic [LEN_W-1:0]   ARLEN;
   logic [SIZE_W-1:0]  ARSIZE;
   logic [BURST_W-1:0] ARBURST;
   logic               ARVALID;
   logic               ARREADY;
   logic [ID_W-1:0]    RID;
   logic [DATA_W-1:0]  RDATA;
   logic [RESP_W-1:0]  RRESP;
   logic               RLAST;
   logic               RVALID;
   logic               RREADY;

   modport master (
      output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
      input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
   );

   modport slave (
      input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
      output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
   );

endinterface

// File: rtl/axi_read_arbiter_rr.sv
// Two-request round-robin arbiter; the pointer moves to the loser after every grant.
module axi_rr_arbiter
   import axi_arb_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o,
   output mst_idx_t   gnt_idx_o
);

   mst_idx_t rr_q, rr_d;

   always_comb begin
      gnt_idx_o = (&req_i) ? rr_q : mst_idx_t'(req_i[1]);
      gnt_o     = 2'b00;
      rr_d      = rr_q;
      if (|req_i) begin
         gnt_o[gnt_idx_o] = 1'b1;
         rr_d             = ~gnt_idx_o;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) rr_q <= MST_M0;
      else         rr_q <= rr_d;
   end

endmodule

// File: rtl/axi_read_arbiter.sv
// Two-master / two-slave AXI read arbiter with a single transaction in flight.
// Build option AXI_DEFAULT_SLAVE_EN: unmapped addresses get DECERR beats locally.
module axi_read_arbiter
   import axi_arb_pkg::*;
#(
   parameter logic [31:0] SLV0_BASE = 32'h0000_0000,
   parameter logic [31:0] SLV1_BASE = 32'h0001_0000,
   parameter logic [31:0] SLV_SIZE  = 32'h0001_0000
) (
   input  logic     ACLK,
   input  logic     ARESETn,
   axi_rd_if.slave  m0,
   axi_rd_if.slave  m1,
   axi_rd_if.master s0,
   axi_rd_if.master s1
);

   state_t            state_q, state_d;
   ar_pld_t           pld_q, pld_d;
   mst_idx_t          mst_q, mst_d;
   slv_sel_t          slv_q, slv_d;

   logic [1:0]        req;
   logic [1:0]        gnt;
   mst_idx_t          gnt_idx;
   ar_pld_t           req_pld;
   slv_sel_t          dec_slv;
   logic              dec_hit;

   logic              sel_arready, sel_rvalid, sel_rlast, m_rready;
   logic [DATA_W-1:0] sel_rdata;
   logic [RESP_W-1:0] sel_rresp;
   logic [MID_W-1:0]  sel_rid;

   logic              r_vld, r_last;
   logic [DATA_W-1:0] r_data;
   logic [RESP_W-1:0] r_resp;
   logic [MID_W-1:0]  r_id;
   logic              unused_bits;

   // Requests are only visible in IDLE and out of reset, so ARREADY can never fire elsewhere.
   assign req = (ARESETn && state_q == ST_IDLE) ? {m1.ARVALID, m0.ARVALID} : 2'b00;

   axi_rr_arbiter u_rr (
      .clk_i     (ACLK),
      .rst_ni    (ARESETn),
      .req_i     (req),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx)
   );

   assign m0.ARREADY = gnt[0];
   assign m1.ARREADY = gnt[1];

   assign req_pld = gnt_idx ? {m1.ARID, m1.ARADDR, m1.ARLEN, m1.ARSIZE, m1.ARBURST}
                            : {m0.ARID, m0.ARADDR, m0.ARLEN, m0.ARSIZE, m0.ARBURST};

`ifdef AXI_DEFAULT_SLAVE_EN
   logic             hit0, hit1;
   logic             def_last;
   logic [LEN_W-1:0] beat_q, beat_d;

   // 33-bit bounds so a window ending at 4 GiB cannot wrap.
   assign hit0 = ({1'b0, req_pld.addr} >= {1'b0, SLV0_BASE}) &&
                 ({1'b0, req_pld.addr} <  ({1'b0, SLV0_BASE} + {1'b0, SLV_SIZE}));
   assign hit1 = ({1'b0, req_pld.addr} >= {1'b0, SLV1_BASE}) &&
                 ({1'b0, req_pld.addr} <  ({1'b0, SLV1_BASE} + {1'b0, SLV_SIZE}));
   assign dec_slv     = hit1 && !hit0;
   assign dec_hit     = hit0 || hit1;
   assign def_last    = (beat_q == pld_q.len);
   assign unused_bits = ^{s0.RID[SID_W-1:MID_W], s1.RID[SID_W-1:MID_W]};
`else
   assign dec_slv     = req_pld.addr[16];
   assign dec_hit     = 1'b1;
   assign unused_bits = ^{s0.RID[SID_W-1:MID_W], s1.RID[SID_W-1:MID_W],
                          SLV0_BASE, SLV1_BASE, SLV_SIZE};
`endif

   assign sel_arready = slv_q ? s1.ARREADY : s0.ARREADY;
   assign sel_rvalid  = slv_q ? s1.RVALID  : s0.RVALID;
   assign sel_rlast   = slv_q ? s1.RLAST   : s0.RLAST;
   assign sel_rdata   = slv_q ? s1.RDATA   : s0.RDATA;
   assign sel_rresp   = slv_q ? s1.RRESP   : s0.RRESP;
   assign sel_rid     = slv_q ? s1.RID[MID_W-1:0] : s0.RID[MID_W-1:0];
   assign m_rready    = mst_q ? m1.RREADY  : m0.RREADY;

   always_comb begin
      state_d = state_q;
      pld_d   = pld_q;
      mst_d   = mst_q;
      slv_d   = slv_q;
`ifdef AXI_DEFAULT_SLAVE_EN
      beat_d  = beat_q;
`endif
      case (state_q)
         ST_IDLE: if (|gnt) begin
            pld_d   = req_pld;
            mst_d   = gnt_idx;
            slv_d   = dec_slv;
            state_d = dec_hit ? ST_ADDR : ST_DEFR;
`ifdef AXI_DEFAULT_SLAVE_EN
            beat_d  = '0;
`endif
         end
         ST_ADDR: if (sel_arready) state_d = ST_DATA;
         ST_DATA: if (sel_rvalid && m_rready && sel_rlast) state_d = ST_IDLE;
`ifdef AXI_DEFAULT_SLAVE_EN
         ST_DEFR: if (m_rready) begin
            if (def_last) state_d = ST_IDLE;
            else          beat_d  = beat_q + LEN_W'(1);
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         state_q <= ST_IDLE;
         pld_q   <= '0;
         mst_q   <= MST_M0;
         slv_q   <= 1'b0;
`ifdef AXI_DEFAULT_SLAVE_EN
         beat_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         pld_q   <= pld_d;
         mst_q   <= mst_d;
         slv_q   <= slv_d;
`ifdef AXI_DEFAULT_SLAVE_EN
         beat_q  <= beat_d;
`endif
      end
   end

   // Slave AR channel: only the decoded slave sees the request, and only in ADDR.
   always_comb begin
      s0.ARVALID = 1'b0; s0.ARID = '0; s0.ARADDR = '0; s0.ARLEN = '0; s0.ARSIZE = '0; s0.ARBURST = '0;
      s1.ARVALID = 1'b0; s1.ARID = '0; s1.ARADDR = '0; s1.ARLEN = '0; s1.ARSIZE = '0; s1.ARBURST = '0;
      if (ARESETn && state_q == ST_ADDR) begin
         if (slv_q) begin
            s1.ARVALID = 1'b1;
            s1.ARID    = {3'b000, mst_q, pld_q.id};
            s1.ARADDR  = pld_q.addr;
            s1.ARLEN   = pld_q.len;
            s1.ARSIZE  = pld_q.size;
            s1.ARBURST = pld_q.burst;
         end else begin
            s0.ARVALID = 1'b1;
            s0.ARID    = {3'b000, mst_q, pld_q.id};
            s0.ARADDR  = pld_q.addr;
            s0.ARLEN   = pld_q.len;
            s0.ARSIZE  = pld_q.size;
            s0.ARBURST = pld_q.burst;
         end
      end
   end

   assign s0.RREADY = ARESETn && (state_q == ST_DATA) && !slv_q && m_rready;
   assign s1.RREADY = ARESETn && (state_q == ST_DATA) &&  slv_q && m_rready;

   always_comb begin
      r_vld  = 1'b0;
      r_last = 1'b0;
      r_data = '0;
      r_resp = '0;
      r_id   = '0;
      if (ARESETn && state_q == ST_DATA) begin
         r_vld  = sel_rvalid;
         r_last = sel_rlast;
         r_data = sel_rdata;
         r_resp = sel_rresp;
         r_id   = sel_rid;
      end
`ifdef AXI_DEFAULT_SLAVE_EN
      else if (ARESETn && state_q == ST_DEFR) begin
         r_vld  = 1'b1;
         r_last = def_last;
         r_resp = RRESP_DECERR;
         r_id   = pld_q.id;
      end
`endif
   end

   always_comb begin
      m0.RVALID = r_vld && !mst_q;
      m0.RLAST  = mst_q ? 1'b0 : r_last;
      m0.RDATA  = mst_q ? '0   : r_data;
      m0.RRESP  = mst_q ? '0   : r_resp;
      m0.RID    = mst_q ? '0   : r_id;
      m1.RVALID = r_vld && mst_q;
      m1.RLAST  = mst_q ? r_last : 1'b0;
      m1.RDATA  = mst_q ? r_data : '0;
      m1.RRESP  = mst_q ? r_resp : '0;
      m1.RID    = mst_q ? r_id   : '0;
   end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Randomised bench for axi_read_arbiter against a transaction-level reference model.
module tb_axi_read_arbiter;

   localparam longint S0_BASE = 64'h0000_0000;
   localparam longint S1_BASE = 64'h0001_0000;
   localparam longint WIN     = 64'h0001_0000;

   logic ACLK    = 1'b0;
   logic ARESETn = 1'b0;
   int   checks  = 0;
   int   errors  = 0;
   int   exp_rr  = 0;   // master that wins the next contention

   always #5 ACLK = ~ACLK;

   axi_rd_if #(.ID_W(4)) m0 ();
   axi_rd_if #(.ID_W(4)) m1 ();
   axi_rd_if #(.ID_W(8)) s0 ();
   axi_rd_if #(.ID_W(8)) s1 ();

   axi_read_arbiter dut (
      .ACLK    (ACLK),
      .ARESETn (ARESETn),
      .m0      (m0),
      .m1      (m1),
      .s0      (s0),
      .s1      (s1)
   );

   function automatic int exp_slave(input logic [31:0] a);
`ifdef AXI_DEFAULT_SLAVE_EN
      longint ua;
      ua = longint'(a);
      if (ua < S0_BASE + WIN && ua >= S0_BASE) return 0;
      if (ua < S1_BASE + WIN && ua >= S1_BASE) return 1;
      return -1;
`else
      return a[16] ? 1 : 0;
`endif
   endfunction

   function automatic logic        m_arready(input int w); return (w != 0) ? m1.ARREADY : m0.ARREADY; endfunction
   function automatic logic        m_rvalid (input int w); return (w != 0) ? m1.RVALID  : m0.RVALID;  endfunction
   function automatic logic [31:0] m_rdata  (input int w); return (w != 0) ? m1.RDATA   : m0.RDATA;   endfunction
   function automatic logic [3:0]  m_rid    (input int w); return (w != 0) ? m1.RID     : m0.RID;     endfunction
   function automatic logic [1:0]  m_rresp  (input int w); return (w != 0) ? m1.RRESP   : m0.RRESP;   endfunction
   function automatic logic        m_rlast  (input int w); return (w != 0) ? m1.RLAST   : m0.RLAST;   endfunction
   function automatic logic        s_arvalid(input int y); return (y != 0) ? s1.ARVALID : s0.ARVALID; endfunction
   function automatic logic [31:0] s_araddr (input int y); return (y != 0) ? s1.ARADDR  : s0.ARADDR;  endfunction
   function automatic logic [7:0]  s_arid   (input int y); return (y != 0) ? s1.ARID    : s0.ARID;    endfunction
   function automatic logic [3:0]  s_arlen  (input int y); return (y != 0) ? s1.ARLEN   : s0.ARLEN;   endfunction
   function automatic logic        s_rready (input int y); return (y != 0) ? s1.RREADY  : s0.RREADY;  endfunction

   function automatic logic [183:0] all_outs();
      return {m0.ARREADY, m0.RID, m0.RDATA, m0.RRESP, m0.RLAST, m0.RVALID,
              m1.ARREADY, m1.RID, m1.RDATA, m1.RRESP, m1.RLAST, m1.RVALID,
              s0.ARID, s0.ARADDR, s0.ARLEN, s0.ARSIZE, s0.ARBURST, s0.ARVALID, s0.RREADY,
              s1.ARID, s1.ARADDR, s1.ARLEN, s1.ARSIZE, s1.ARBURST, s1.ARVALID, s1.RREADY};
   endfunction

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic set_mar(input int w, input logic v, input logic [31:0] a,
                          input logic [3:0] len, input logic [3:0] id);
      if (w == 0) begin
         m0.ARVALID = v; m0.ARADDR = a; m0.ARLEN = len; m0.ARID = id; m0.ARSIZE = 3'd2; m0.ARBURST = 2'b01;
      end else begin
         m1.ARVALID = v; m1.ARADDR = a; m1.ARLEN = len; m1.ARID = id; m1.ARSIZE = 3'd2; m1.ARBURST = 2'b01;
      end
   endtask

   task automatic set_mvalid(input int w, input logic v);
      if (w == 0) m0.ARVALID = v; else m1.ARVALID = v;
   endtask

   task automatic set_m_rready(input int w, input logic v);
      if (w == 0) m0.RREADY = v; else m1.RREADY = v;
   endtask

   task automatic set_s_arready(input int y, input logic v);
      if (y == 0) s0.ARREADY = v; else s1.ARREADY = v;
   endtask

   task automatic set_s_r(input int y, input logic v, input logic [31:0] d,
                          input logic [7:0] id, input logic [1:0] resp, input logic last);
      if (y == 0) begin
         s0.RVALID = v; s0.RDATA = d; s0.RID = id; s0.RRESP = resp; s0.RLAST = last;
      end else begin
         s1.RVALID = v; s1.RDATA = d; s1.RID = id; s1.RRESP = resp; s1.RLAST = last;
      end
   endtask

   task automatic clear_inputs();
      set_mar(0, 1'b0, '0, '0, '0);
      set_mar(1, 1'b0, '0, '0, '0);
      m0.RREADY = 1'b0; m1.RREADY = 1'b0;
      s0.ARREADY = 1'b0; s1.ARREADY = 1'b0;
      set_s_r(0, 1'b0, '0, '0, '0, 1'b0);
      set_s_r(1, 1'b0, '0, '0, '0, 1'b0);
   endtask

   // One complete read transaction, starting and ending mid-cycle in IDLE.
   task automatic run_txn(input logic v0, input logic v1, input logic [31:0] a0, input logic [31:0] a1,
                          input logic [3:0] l0, input logic [3:0] l1, input logic [3:0] i0,
                          input logic [3:0] i1, input int ardly, input int stall, input string tag);
      int w, y, got, cyc;
      logic lv, pres, rr_m;
      logic [31:0] a, cur;
      logic [3:0] l, id;
      logic [1:0] cresp;
      logic [7:0] sid;
      w  = (v0 && v1) ? exp_rr : (v1 ? 1 : 0);
      exp_rr = (w == 0) ? 1 : 0;
      lv = v0 && v1;
      a  = (w != 0) ? a1 : a0;
      l  = (w != 0) ? l1 : l0;
      id = (w != 0) ? i1 : i0;
      sid = {4'(w), id};
      y  = exp_slave(a);
      set_mar(0, v0, a0, l0, i0);
      set_mar(1, v1, a1, l1, i1);
      #1;
      checks++;
      if (m_arready(w) !== 1'b1 || m_arready(1 - w) !== 1'b0)
         begin errors++; $display("FAIL %s grant: arready_m%0d=%b arready_m%0d=%b, required 1/0", tag, w, m_arready(w), 1 - w, m_arready(1 - w)); end
      tick();
      set_mvalid(w, 1'b0);
      got = 0; cyc = 0; pres = 1'b0; cur = '0; cresp = '0;
      if (y >= 0) begin
         for (int c = 0; c <= ardly; c++) begin
            set_s_arready(y, c == ardly);
            #1;
            checks++;
            if (s_arvalid(y) !== 1'b1 || s_araddr(y) !== a || s_arid(y) !== sid || s_arlen(y) !== l)
               begin errors++; $display("FAIL %s ar_s%0d c%0d: vld=%b addr=%h id=%h len=%h, required 1 %h %h %h", tag, y, c, s_arvalid(y), s_araddr(y), s_arid(y), s_arlen(y), a, sid, l); end
            checks++;
            if (s_arvalid(1 - y) !== 1'b0 || m_arready(1 - w) !== 1'b0)
               begin errors++; $display("FAIL %s ar_excl: other arvalid=%b other arready=%b, required 0/0", tag, s_arvalid(1 - y), m_arready(1 - w)); end
            tick();
         end
         set_s_arready(y, 1'b0);
         while (got <= int'(l) && cyc < 300) begin
            if (!pres) begin
               pres  = ($urandom_range(0, 3) != 0);
               cur   = $urandom;
               cresp = 2'($urandom_range(0, 3));
            end
            rr_m = ($urandom_range(0, 99) >= stall);
            set_s_r(y, pres, cur, sid, cresp, pres && (got == int'(l)));
            set_m_rready(w, rr_m);
            #1;
            checks++;
            if (m_rvalid(w) !== pres || m_rvalid(1 - w) !== 1'b0 || s_rready(y) !== rr_m || s_rready(1 - y) !== 1'b0)
               begin errors++; $display("FAIL %s r_hs beat%0d: rvalid=%b other=%b rready_s=%b other=%b, required %b 0 %b 0", tag, got, m_rvalid(w), m_rvalid(1 - w), s_rready(y), s_rready(1 - y), pres, rr_m); end
            if (pres) begin
               checks++;
               if (m_rdata(w) !== cur || m_rid(w) !== id || m_rresp(w) !== cresp || m_rlast(w) !== (got == int'(l)))
                  begin errors++; $display("FAIL %s r_beat%0d: data=%h id=%h resp=%b last=%b, required %h %h %b %b", tag, got, m_rdata(w), m_rid(w), m_rresp(w), m_rlast(w), cur, id, cresp, got == int'(l)); end
            end
            tick();
            if (pres && rr_m) begin got++; pres = 1'b0; end
            cyc++;
         end
      end
`ifdef AXI_DEFAULT_SLAVE_EN
      else begin
         while (got <= int'(l) && cyc < 300) begin
            rr_m = ($urandom_range(0, 99) >= stall);
            set_m_rready(w, rr_m);
            #1;
            checks++;
            if (m_rvalid(w) !== 1'b1 || m_rresp(w) !== 2'b11 || m_rdata(w) !== 32'h0 || m_rid(w) !== id || m_rlast(w) !== (got == int'(l)))
               begin errors++; $display("FAIL %s decerr beat%0d: vld=%b resp=%b data=%h id=%h last=%b, required 1 11 0 %h %b", tag, got, m_rvalid(w), m_rresp(w), m_rdata(w), m_rid(w), m_rlast(w), id, got == int'(l)); end
            checks++;
            if (s_arvalid(0) !== 1'b0 || s_arvalid(1) !== 1'b0 || m_rvalid(1 - w) !== 1'b0)
               begin errors++; $display("FAIL %s decerr_excl: arvalid_s0=%b arvalid_s1=%b other rvalid=%b, required 0", tag, s_arvalid(0), s_arvalid(1), m_rvalid(1 - w)); end
            tick();
            if (rr_m) got++;
            cyc++;
         end
      end
`endif
      checks++;
      if (cyc >= 300) begin errors++; $display("FAIL %s timeout: beats=%0d, required %0d", tag, got, int'(l) + 1); end
      set_s_r(0, 1'b0, '0, '0, '0, 1'b0);
      set_s_r(1, 1'b0, '0, '0, '0, 1'b0);
      set_m_rready(w, 1'b0);
      #1;
      checks++;
      if (m_rvalid(w) !== 1'b0 || (lv && m_arready(1 - w) !== 1'b1))
         begin errors++; $display("FAIL %s back_to_idle: rvalid=%b pending arready=%b, required 0 and %b", tag, m_rvalid(w), m_arready(1 - w), lv); end
      set_mvalid(1 - w, 1'b0);
      #1;
   endtask

   task automatic test_reset();
      clear_inputs();
      ARESETn = 1'b0;
      set_mar(0, 1'b1, 32'h10, 4'd0, 4'h1);
      set_mar(1, 1'b1, 32'h0001_0010, 4'd0, 4'h2);
      s0.RVALID = 1'b1; s1.RVALID = 1'b1; s0.ARREADY = 1'b1;
      tick(); tick();
      checks++;
      if (all_outs() !== '0) begin errors++; $display("FAIL reset_outs: outputs=%h, required 0", all_outs()); end
      clear_inputs();
      ARESETn = 1'b1;
      exp_rr  = 0;
      tick();
      checks++;
      if (all_outs() !== '0) begin errors++; $display("FAIL reset_idle: outputs=%h, required 0", all_outs()); end
   endtask

   task automatic test_contention();
      run_txn(1'b1, 1'b1, 32'h0000_0100, 32'h0001_0200, 4'd0, 4'd1, 4'h3, 4'h7, 0, 0, "contend1");
      run_txn(1'b1, 1'b1, 32'h0000_0300, 32'h0001_0400, 4'd2, 4'd0, 4'h4, 4'h8, 1, 20, "contend2");
   endtask

   task automatic test_basic();
      run_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'd0, 4'd0, 4'h2, 4'h0, 0, 0, "basic");
   endtask

   task automatic test_burst_m1();
      run_txn(1'b0, 1'b1, 32'h0, 32'h0001_0004, 4'd0, 4'd3, 4'h0, 4'h9, 1, 50, "burst_m1");
   endtask

   task automatic test_ar_stall();
      run_txn(1'b1, 1'b1, 32'h0001_0040, 32'h0001_0080, 4'd2, 4'd1, 4'h1, 4'h2, 5, 30, "ar_stall");
   endtask

`ifdef AXI_DEFAULT_SLAVE_EN
   task automatic test_default_slave();
      run_txn(1'b1, 1'b0, 32'h2000_0000, 32'h0, 4'd1, 4'd0, 4'h6, 4'h0, 0, 30, "defslave");
   endtask
`endif

   task automatic test_random();
      int pat;
      logic [31:0] a0, a1;
      for (int n = 0; n < 30; n++) begin
         pat = $urandom_range(1, 3);
         a0  = ($urandom_range(0, 1) != 0 ? 32'h0001_0000 : 32'h0) | ({16'h0, 16'($urandom)} & 32'h0000_FFFC);
         a1  = ($urandom_range(0, 1) != 0 ? 32'h0001_0000 : 32'h0) | ({16'h0, 16'($urandom)} & 32'h0000_FFFC);
`ifdef AXI_DEFAULT_SLAVE_EN
         if ($urandom_range(0, 4) == 0) a0 = 32'h4000_0000 | a0;
         if ($urandom_range(0, 4) == 0) a1 = 32'hF000_0000 | a1;
`endif
         run_txn(pat[0], pat[1], a0, a1, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                 4'($urandom), 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 60), "random");
      end
   endtask

   task automatic test_reset_mid();
      set_mar(1, 1'b1, 32'h0001_0004, 4'd3, 4'h5);
      #1;
      tick();
      set_mvalid(1, 1'b0);
      set_s_arready(1, 1'b1);
      tick();
      set_s_arready(1, 1'b0);
      set_s_r(1, 1'b1, 32'hAAAA_0001, 8'h15, 2'b00, 1'b0);
      set_m_rready(1, 1'b1);
      tick();
      set_s_r(1, 1'b1, 32'hAAAA_0002, 8'h15, 2'b00, 1'b0);
      ARESETn = 1'b0;
      tick();
      checks++;
      if (all_outs() !== '0) begin errors++; $display("FAIL rst_mid_outs: outputs=%h, required 0", all_outs()); end
      ARESETn = 1'b1;
      exp_rr  = 0;
      tick();
      checks++;
      if (m1.RVALID !== 1'b0 || s1.RREADY !== 1'b0 || s1.ARVALID !== 1'b0)
         begin errors++; $display("FAIL rst_mid_abandon: rvalid_m1=%b rready_s1=%b arvalid_s1=%b, required 0", m1.RVALID, s1.RREADY, s1.ARVALID); end
      clear_inputs();
      #1;
      run_txn(1'b1, 1'b1, 32'h0000_0020, 32'h0001_0020, 4'd0, 4'd0, 4'hA, 4'hB, 0, 0, "rst_mid_rr");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      clear_inputs();
      test_reset();
      test_contention();
      test_basic();
      test_burst_m1();
      test_ar_stall();
`ifdef AXI_DEFAULT_SLAVE_EN
      test_default_slave();
`endif
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi_read_arbiter.md
AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 Parameter SLV0_BASE, default 32'h0000_0000, base address of slave 0.
REQ-002 Parameter SLV1_BASE, default 32'h0001_0000, base address of slave 1.
REQ-003 Parameter SLV_SIZE, default 32'h0001_0000, byte span of each slave window.
REQ-004 ACLK  input  1  single clock; all state updates on the rising edge.
REQ-005 ARESETn  input  1  reset, synchronous, active-low.
REQ-006 ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID_M0, _M1  input  4/32/4/3/2/1  master read-address requests.
REQ-007 ARREADY_M0, ARREADY_M1  output  1  read-address accept, per master.
REQ-008 RID/RDATA/RRESP/RLAST/RVALID_M0, _M1  output  4/32/2/1/1  read data to masters; RREADY_M0, RREADY_M1  input  1.
REQ-009 ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID_S0, _S1  output  8/32/4/3/2/1  address to slaves; ARREADY_S0, ARREADY_S1  input  1.
REQ-010 RID/RDATA/RRESP/RLAST/RVALID_S0, _S1  input  8/32/2/1/1  slave read data; RREADY_S0, RREADY_S1  output  1.

Function
REQ-011 States SHALL be IDLE, ADDR, DATA, DEFR; one read transaction in flight at a time.
REQ-012 IDLE: grant SHALL go to the single valid master; if both ARVALID high, to the master named by round-robin pointer rr.
REQ-013 In IDLE, ARREADY_Mx SHALL be driven combinationally high only for the granted master; on that handshake the AR payload and master index SHALL be registered and state SHALL go to ADDR (or DEFR, REQ-020).
REQ-014 After each grant, rr SHALL point to the non-granted master.
REQ-015 Decode: ARADDR in [SLV0_BASE, SLV0_BASE+SLV_SIZE) selects S0; in [SLV1_BASE, SLV1_BASE+SLV_SIZE) selects S1; comparison full 32-bit, no wrap.
REQ-016 ADDR: ARVALID_Sy SHALL be high from the cycle after master handshake until ARREADY_Sy; ARID_Sy = {4'(master index), registered ARID}; other fields registered copies; then state DATA.
REQ-017 DATA: RVALID_Mx = RVALID_Sy, RREADY_Sy = RREADY_Mx, RDATA/RRESP/RLAST passed combinationally, RID_Mx = RID_Sy[3:0]; all other masters' RVALID low.
REQ-018 DATA SHALL return to IDLE the cycle after RVALID&RREADY&RLAST; a new grant is possible in that IDLE cycle.
REQ-019 Unselected slave ARVALID/RREADY and ungranted ARREADY SHALL be 0 in every state.

Reset
REQ-020 While ARESETn low at a clock edge: state IDLE, rr = M0, registered payload cleared; all VALID/READY outputs 0, all data/ID/resp outputs 0.
REQ-021 Reset mid-transaction SHALL abandon the transaction without further beats; no slave handshake after reset.

Configuration
REQ-022 AXI_DEFAULT_SLAVE_EN defined: address matching neither window SHALL enter DEFR, no slave AR issued; DEFR returns ARLEN+1 beats to the master with RRESP=2'b11, RDATA=0, RID=registered ARID, RLAST on final beat, each beat held until RREADY; IDLE after last handshake.
REQ-023 AXI_DEFAULT_SLAVE_EN undefined: decode uses ARADDR[16] only (0 to S0, 1 to S1); DEFR unused/removed.

Structure
REQ-024 Package axi_arb_pkg SHALL hold the state enum, master-index and slave-select typedefs, RRESP_DECERR constant; width macros from AXI_define.svh.
REQ-025 Sub-module axi_rr_arbiter (2-request round-robin, grant plus rr pointer update) SHALL be instantiated; decode and channel muxing remain in top.

Verification
REQ-026 M0 ARVALID, ARADDR=32'h0000_0010, ARLEN=0 -> ARVALID_S0 next cycle, ARID_S0=8'h0?; S0 single beat RLAST -> RVALID_M0 same cycle, IDLE next.
REQ-027 Both masters valid in same cycle after reset -> M0 granted; next contention -> M1 granted.
REQ-028 M1 ARADDR=32'h0001_0004, ARLEN=3, RREADY_M1 toggled -> four beats to M1 only, RVALID_M0 stays 0, stall cycles preserved.
REQ-029 ARREADY_S1 held low 5 cycles -> ARVALID_S1 and ARADDR_S1 stable throughout, no second master accepted.
REQ-030 With AXI_DEFAULT_SLAVE_EN, ARADDR=32'h2000_0000, ARLEN=1 -> two beats RRESP=2'b11, RLAST on second, no ARVALID_S0/S1.
REQ-031 ARESETn low during DATA beat 2 of 4 -> next cycle all outputs 0, state IDLE, rr=M0.
